// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz raster timing, coordinate widths and sync polarities
// shared by the VGA sync generator and its users.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned PIX_DIV_DEF  = 2;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = 9;
    localparam int unsigned FCNT_W = 16;

    localparam bit HS_POL_DEF = 1'b0;
    localparam bit VS_POL_DEF = 1'b0;

    // A divide-by-one still needs a one-bit counter to keep widths legal.
    function automatic int unsigned div_width(int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster outputs of vga_sync_gen; o_frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic             o_pix_stb;
    logic             o_hs;
    logic             o_vs;
    logic             o_active;
    logic [X_W-1:0]   o_x;
    logic [Y_W-1:0]   o_y;
    logic             o_frame_end;
`ifdef VGA_FRAME_CNT_EN
    logic [FCNT_W-1:0] o_frame_cnt;
`endif

`ifdef VGA_FRAME_CNT_EN
    modport master (
        output o_pix_stb, o_hs, o_vs, o_active, o_x, o_y, o_frame_end, o_frame_cnt
    );
    modport slave (
        input  o_pix_stb, o_hs, o_vs, o_active, o_x, o_y, o_frame_end, o_frame_cnt
    );
`else
    modport master (
        output o_pix_stb, o_hs, o_vs, o_active, o_x, o_y, o_frame_end
    );
    modport slave (
        input  o_pix_stb, o_hs, o_vs, o_active, o_x, o_y, o_frame_end
    );
`endif

endinterface

// File: rtl/pix_stb_div.sv
// Pixel-rate divider: step is high on the last clk_in cycle of every PIX_DIV-cycle pixel.
module pix_stb_div
    import vga_timing_pkg::*;
#(
    parameter int unsigned PIX_DIV = PIX_DIV_DEF
) (
    input  logic clk_in,
    input  logic i_rst_n,
    output logic step
);

    localparam int unsigned     DivW    = div_width(PIX_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(PIX_DIV - 1);

    logic [DivW-1:0] div_q, div_d;

    always_comb begin
        step  = (div_q == DivLast);
        div_d = step ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: h/v counters, sync/active decode and aligned output registers.
// Optional frame counter output is enabled by defining VGA_FRAME_CNT_EN.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned PIX_DIV  = PIX_DIV_DEF,
    parameter bit          HS_POL   = HS_POL_DEF,
    parameter bit          VS_POL   = VS_POL_DEF
) (
    input  logic           clk_in,
    input  logic           i_rst_n,
    vga_sync_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] HLast   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] VLast   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HAct    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VAct    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HsStart = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HsEnd   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VsStart = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VsEnd   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             step;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             pix_stb_q;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             active_q, active_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             frame_end_q, frame_end_d;

    pix_stb_div #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_stb_div (
        .clk_in  (clk_in),
        .i_rst_n (i_rst_n),
        .step    (step)
    );

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (step) begin
            if (h_q == HLast) begin
                h_d = '0;
                v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Decode from the post-step counts so every output lands on the same edge.
    always_comb begin
        active_d    = (h_d < HAct) && (v_d < VAct);
        x_d         = (h_d < HAct) ? h_d[X_W-1:0] : '0;
        y_d         = (v_d < VAct) ? v_d[Y_W-1:0] : '0;
        hs_d        = ((h_d >= HsStart) && (h_d < HsEnd)) ? HS_POL : ~HS_POL;
        vs_d        = ((v_d >= VsStart) && (v_d < VsEnd)) ? VS_POL : ~VS_POL;
        frame_end_d = step && (h_d == '0) && (v_d == VAct);
    end

    always_ff @(posedge clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_q         <= HLast;
            v_q         <= VLast;
            pix_stb_q   <= 1'b0;
            frame_end_q <= 1'b0;
            active_q    <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            pix_stb_q   <= step;
            frame_end_q <= frame_end_d;
            if (step) begin
                active_q <= active_d;
                x_q      <= x_d;
                y_q      <= y_d;
                hs_q     <= hs_d;
                vs_q     <= vs_d;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [FCNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_end_d) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign vga.o_frame_cnt = frame_cnt_q;
`endif

    assign vga.o_pix_stb   = pix_stb_q;
    assign vga.o_hs        = hs_q;
    assign vga.o_vs        = vs_q;
    assign vga.o_active    = active_q;
    assign vga.o_x         = x_q;
    assign vga.o_y         = y_q;
    assign vga.o_frame_end = frame_end_q;

endmodule
